divider_unit: RTL and testbench



---
 rtl/divider_unit.sv | 113 +++++++++++
 tb/tb_divider_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Sequential restoring divider producing one quotient bit per clock.
// Optional two's-complement operands when DIVIDER_SIGNED_EN is defined.
module divider_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] r, q, d;
  logic [CW-1:0]    count;
  logic             last_iter;

  logic [WIDTH:0]   r_ext, trial;
  logic [WIDTH-1:0] r_step, q_step;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] q_final, r_final;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  assign dividend_mag = Dividend[WIDTH-1] ? (~Dividend + 1'b1) : Dividend;
  assign divisor_mag  = Divisor[WIDTH-1]  ? (~Divisor + 1'b1)  : Divisor;
  assign q_final      = neg_q ? (~q_step + 1'b1) : q_step;
  assign r_final      = neg_r ? (~r_step + 1'b1) : r_step;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && Start) begin
      neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
      neg_r <= Dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = Dividend;
  assign divisor_mag  = Divisor;
  assign q_final      = q_step;
  assign r_final      = r_step;
`endif

  // The bit shifted out of R is kept so the trial subtraction never loses a carry.
  assign r_ext     = {r, q[WIDTH-1]};
  assign trial     = r_ext - {1'b0, d};
  assign r_step    = trial[WIDTH] ? r_ext[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step    = {q[WIDTH-2:0], ~trial[WIDTH]};
  assign last_iter = (count == CW'(WIDTH - 1));

  assign Busy = (state == CALC);
  assign Done = (state == DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (Start) state_next = (Divisor == '0) ? DONE : CALC;
      CALC: if (last_iter) state_next = DONE;
      DONE: state_next = Start ? HOLD : IDLE;
      HOLD: if (!Start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && Start) begin
        d     <= divisor_mag;
        r     <= '0;
        q     <= dividend_mag;
        count <= '0;
        if (Divisor == '0) begin
          Quotient  <= '1;
          Remainder <= Dividend;
          DivByZero <= 1'b1;
        end else begin
          DivByZero <= 1'b0;
        end
      end else if (state == CALC) begin
        r     <= r_step;
        q     <= q_step;
        count <= count + CW'(1);
        if (last_iter) begin
          Quotient  <= q_final;
          Remainder <= r_final;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: latency, results, hold/re-arm and reset abort.
// Define DIVIDER_SIGNED_EN for both bench and RTL to exercise signed vectors.
module tb_divider_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Dividend = 8'd0;
  logic [7:0] Divisor = 8'd0;
  logic       Busy, Done, DivByZero;
  logic [7:0] Quotient, Remainder;

  int checks = 0;
  int failures = 0;

  divider_unit #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .Quotient(Quotient), .Remainder(Remainder)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle Start request, then follow the operation to its Done pulse.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic ez, input string tag);
    int n;
    int busy_cnt;
    logic [7:0] prev_q;
    @(negedge Clk);
    prev_q   = Quotient;
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(negedge Clk);
    Start    = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (!Done && n < 20) begin
      if (Busy) busy_cnt++;
      if (n == 4 && b != 8'd0) check({tag, "_qhold"}, Quotient, prev_q);
      @(negedge Clk);
      n++;
    end
    check({tag, "_latency"}, n, (b == 8'd0) ? 1 : 9);
    check({tag, "_busy"}, busy_cnt, (b == 8'd0) ? 0 : 8);
    check({tag, "_q"}, Quotient, eq);
    check({tag, "_r"}, Remainder, er);
    check({tag, "_dbz"}, DivByZero, ez);
    $display("txn %s: %0d/%0d -> q=%0d r=%0d dbz=%0b after %0d cycles",
             tag, a, b, Quotient, Remainder, DivByZero, n);
    @(negedge Clk);
    check({tag, "_donepulse"}, Done, 1'b0);
  endtask

  initial begin
    int dones;

    @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_dbz", DivByZero, 1'b0);
    check("rst_q", Quotient, 8'h00);
    check("rst_r", Remainder, 8'h00);
    Reset = 1'b0;
    $display("txn reset: outputs cleared");

`ifndef DIVIDER_SIGNED_EN
    run_div(8'd200, 8'd7, 8'h1C, 8'd4, 1'b0, "u200_7");
    run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "u255_255");
    run_div(8'd255, 8'd200, 8'd1, 8'd55, 1'b0, "u255_200");
`endif
    run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "u5_9");
    run_div(8'd0, 8'd13, 8'd0, 8'd0, 1'b0, "u0_13");
    run_div(8'd100, 8'd0, 8'hFF, 8'h64, 1'b1, "u100_0");
    run_div(8'd3, 8'd1, 8'd3, 8'd0, 1'b0, "u3_1");

    // Held Start: exactly one result; dividend change mid-CALC is ignored.
    @(negedge Clk);
    Dividend = 8'd50;
    Divisor  = 8'd5;
    Start    = 1'b1;
    dones    = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (i == 2) Dividend = 8'd77;
      if (Done) dones++;
    end
    check("hold_dones", dones, 1);
    check("hold_q", Quotient, 8'd10);
    check("hold_r", Remainder, 8'd0);
    check("hold_busy", Busy, 1'b0);
    $display("txn hold: 50/5 with Start held -> q=%0d r=%0d dones=%0d", Quotient, Remainder, dones);
    Start = 1'b0;
    @(negedge Clk);
    run_div(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, "rearm77_5");

    // Reset asserted during the 4th CALC cycle of 200/7.
    @(negedge Clk);
    Dividend = 8'd200;
    Divisor  = 8'd7;
    Start    = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("abort_busy_before", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_q", Quotient, 8'h00);
    check("abort_r", Remainder, 8'h00);
    check("abort_dbz", DivByZero, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Done || Busy) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("txn abort: reset mid-CALC, activity afterwards=%0d", dones);
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, "u9_2");

`ifdef DIVIDER_SIGNED_EN
    run_div(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, "s-100_7");
    run_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, "s-128_-1");
    run_div(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, "s100_-7");
    run_div(8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1, "s-100_0");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
